ctr_decoder: RTL

CTR_DECODER -- requirements
Module: ctr_decoder

---
 rtl/ctr_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ctr_decoder.sv
// ctr_decoder: decodes the serial cal-trg-res command line.
// A command is a start bit 1 followed by bits b1, b2 in consecutive sync
// slots and at least one 0 separator slot. {b1,b2} selects
// 00 cal / 10 trg / 11 res_roc / 01 res_tbm. A 1 seen in the separator
// slot raises frame_err and is taken as the start bit of the next command.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   sync       bit-slot enable; ctr_in is sampled only when sync=1
//   ctr_in     serial command line
//   cnt_clr    synchronous clear of all counters (ignores sync)
//   cal, trg, res_roc, res_tbm  one-clk decoded command pulses
//   busy       high while a command is in flight (B1, B2, GAP)
//   frame_err  one-clk pulse on a separator violation
//   trg_cnt, cal_cnt, err_cnt   wrapping event counters
module ctr_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  input  logic             ctr_in,
  input  logic             cnt_clr,
  output logic             cal,
  output logic             trg,
  output logic             res_roc,
  output logic             res_tbm,
  output logic             busy,
  output logic             frame_err,
  output logic [CNT_W-1:0] trg_cnt,
  output logic [CNT_W-1:0] cal_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B1   = 2'd1,
    S_B2   = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              b1_q, b1_d;
  logic              cal_q, cal_d;
  logic              trg_q, trg_d;
  logic              roc_q, roc_d;
  logic              tbm_q, tbm_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  trg_cnt_q, trg_cnt_d;
  logic [CNT_W-1:0]  cal_cnt_q, cal_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Next-state, decode and counter logic
  always_comb begin
    state_d = state_q;
    b1_d    = b1_q;
    cal_d   = 1'b0;
    trg_d   = 1'b0;
    roc_d   = 1'b0;
    tbm_d   = 1'b0;
    err_d   = 1'b0;

    if (sync) begin
      unique case (state_q)
        S_IDLE: begin
          if (ctr_in) state_d = S_B1;
        end
        S_B1: begin
          b1_d    = ctr_in;
          state_d = S_B2;
        end
        S_B2: begin
          // b2 is consumed on its own sample edge; the pulse registers carry it
          unique case ({b1_q, ctr_in})
            2'b00:   cal_d = 1'b1;
            2'b10:   trg_d = 1'b1;
            2'b11:   roc_d = 1'b1;
            default: tbm_d = 1'b1;
          endcase
          state_d = S_GAP;
        end
        S_GAP: begin
          // A 1 in the separator slot is both an error and a new start bit
          if (ctr_in) begin
            err_d   = 1'b1;
            state_d = S_B1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);

    // Counters advance on the edge that raises their pulse; clear wins
    if (cnt_clr) begin
      trg_cnt_d = '0;
      cal_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      trg_cnt_d = trg_cnt_q + CNT_W'(trg_d);
      cal_cnt_d = cal_cnt_q + CNT_W'(cal_d);
      err_cnt_d = err_cnt_q + CNT_W'(err_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      b1_q      <= 1'b0;
      cal_q     <= 1'b0;
      trg_q     <= 1'b0;
      roc_q     <= 1'b0;
      tbm_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      trg_cnt_q <= '0;
      cal_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      b1_q      <= b1_d;
      cal_q     <= cal_d;
      trg_q     <= trg_d;
      roc_q     <= roc_d;
      tbm_q     <= tbm_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      trg_cnt_q <= trg_cnt_d;
      cal_cnt_q <= cal_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cal       = cal_q;
  assign trg       = trg_q;
  assign res_roc   = roc_q;
  assign res_tbm   = tbm_q;
  assign frame_err = err_q;
  assign busy      = busy_q;
  assign trg_cnt   = trg_cnt_q;
  assign cal_cnt   = cal_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
